// File: rtl/pipe_ctrl_pkg.sv
// Shared core types: register index, datapath width and controller states.
package pipe_ctrl_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] r_t;

    typedef enum logic {
        RUN      = 1'b0,
        DIV_BUSY = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of a load in EX.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  r_t   rs1,
    input  r_t   rs2,
    input  logic use_rs1,
    input  logic use_rs2,
    input  r_t   rd,
    input  logic is_load,
    output logic hazard
);

    // x0 is hardwired to zero, so a load into it never creates a dependency.
    always_comb begin
        hazard = is_load && (rd != 5'd0) &&
                 ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: freezes, divide stalls, branch flushes and load-use bubbles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  r_t               id_rs1,
    input  r_t               id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  r_t               ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_br_taken,
    input  logic             ex_div_start,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             div_done,
    output logic [CNT_W-1:0] stall_cnt
);

    // The start cycle is one of the stall cycles, so the counter covers the rest.
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    ctrl_state_t state, state_next;
    logic [7:0]  div_cnt, div_cnt_next;
    logic        load_use;
    logic        freeze;

    hazard_detect u_hazard (
        .rs1     (id_rs1),
        .rs2     (id_rs2),
        .use_rs1 (id_use_rs1),
        .use_rs2 (id_use_rs2),
        .rd      (ex_rd),
        .is_load (ex_is_load),
        .hazard  (load_use)
    );

    assign freeze = mem_req && !mem_ready;

    // Prioritised control decode; a freeze holds everything, including the divide countdown.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        div_done     = 1'b0;
        state_next   = state;
        div_cnt_next = div_cnt;

        if (freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (state == DIV_BUSY) begin
            if (div_cnt != 8'd0) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
                div_cnt_next = div_cnt - 8'd1;
            end else begin
                div_done   = 1'b1;
                state_next = RUN;
            end
        end else if (ex_div_start) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            div_cnt_next = DIV_LOAD;
            state_next   = DIV_BUSY;
        end else if (ex_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // State and divide countdown register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            div_cnt <= 8'd0;
        end else begin
            state   <= state_next;
            div_cnt <= div_cnt_next;
        end
    end

    // Performance counter of fetch-stalled cycles; wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!pc_en) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised and directed bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int DIV_CYCLES = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    r_t   id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken, ex_div_start, mem_req, mem_ready;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, div_done;
    logic [31:0] stall_cnt;

    logic pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4;
    logic if_id_flush4, id_ex_flush4, ex_mem_flush4, div_done4;
    logic [3:0] stall_cnt4;

    int total = 0;
    int bad = 0;

    // Model state: whether a divide is in flight and how many unfrozen cycles it has used.
    bit      m_in_div;
    int      m_div_age;
    longint  m_stalls;

    int      cycle_no;
    int      done_seen_at;
    bit      done_any;

    pipe_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
        .ex_div_start(ex_div_start), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .div_done(div_done), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
        .ex_div_start(ex_div_start), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_en(id_ex_en4), .ex_mem_en(ex_mem_en4),
        .mem_wb_en(mem_wb_en4), .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
        .ex_mem_flush(ex_mem_flush4), .div_done(div_done4), .stall_cnt(stall_cnt4)
    );

    // 10 ns core clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", tag, cycle_no, observed, expected);
        end
    endtask

    // Expected outputs packed as {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem flushes, div_done}.
    function automatic logic [8:0] modelOutputs();
        bit frz, hz;
        frz = mem_req && !mem_ready;
        hz  = ex_is_load && ex_rd != 0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (frz)                                return 9'b00000_000_0;
        if (m_in_div && m_div_age < DIV_CYCLES) return 9'b00011_001_0;
        if (m_in_div)                           return 9'b11111_000_1;
        if (ex_div_start)                       return 9'b00011_001_0;
        if (ex_br_taken)                        return 9'b11111_110_0;
        if (hz)                                 return 9'b00111_010_0;
        return 9'b11111_000_0;
    endfunction

    // Drive one cycle of inputs, compare against the model, then advance the model.
    task automatic applyStimulus(input r_t rs1, input r_t rs2, input logic u1, input logic u2,
                                 input r_t rd, input logic ld, input logic br, input logic dv,
                                 input logic rq, input logic rdy);
        logic [8:0] exp_v, got_v, got4_v;
        @(negedge clk);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_is_load = ld; ex_br_taken = br; ex_div_start = dv;
        mem_req = rq; mem_ready = rdy;
        #2;
        exp_v  = modelOutputs();
        got_v  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush, div_done};
        got4_v = {pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4, if_id_flush4, id_ex_flush4, ex_mem_flush4, div_done4};
        checkOutput("ctrl", 32'(got_v), 32'(exp_v));
        checkOutput("ctrl_w4", 32'(got4_v), 32'(exp_v));
        checkOutput("stall_cnt", stall_cnt, 32'(m_stalls));
        checkOutput("stall_cnt_w4", 32'(stall_cnt4), 32'(m_stalls % 16));
        if (got_v[0] && !done_any) begin
            done_any = 1'b1;
            done_seen_at = cycle_no;
        end
        if (rst_n) begin
            if (!exp_v[8]) m_stalls++;
            if (!(mem_req && !mem_ready)) begin
                if (m_in_div) begin
                    if (m_div_age >= DIV_CYCLES) m_in_div = 1'b0;
                    else m_div_age++;
                end else if (ex_div_start) begin
                    m_in_div  = 1'b1;
                    m_div_age = 1;
                end
            end
        end
        cycle_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic modelReset();
        m_in_div = 1'b0;
        m_div_age = 0;
        m_stalls = 0;
    endtask

    task automatic markStart();
        cycle_no = 0;
        done_any = 1'b0;
        done_seen_at = -1;
    endtask

    initial begin
        modelReset();
        markStart();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
        ex_is_load = 0; ex_br_taken = 0; ex_div_start = 0; mem_req = 0; mem_ready = 0;

        // Reset state: defaults while held in reset and just after.
        idle(2);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        // Load-use bubble, then the same with rd = x0.
        applyStimulus(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        checkOutput("loaduse_cnt", stall_cnt, 32'd1);
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        checkOutput("x0_cnt", stall_cnt, 32'd1);

        // Branch together with a load-use match: the flush wins.
        applyStimulus(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Plain divide: div_done exactly DIV_CYCLES cycles after the start.
        markStart();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1'b1, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 0, 0);
        idle(4);
        checkOutput("div_done_at", 32'(done_seen_at), 32'd8);
        checkOutput("div_cnt", stall_cnt, 32'd9);

        // Divide with a 3-cycle freeze starting at T+2.
        markStart();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1'b1, 0, 0);
        idle(1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        idle(10);
        checkOutput("frz_done_at", 32'(done_seen_at), 32'd11);
        checkOutput("frz_cnt", stall_cnt, 32'd20);

        // Reset in the middle of a divide: no div_done, counter cleared.
        markStart();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1'b1, 0, 0);
        idle(3);
        @(negedge clk);
        rst_n = 1'b0;
        modelReset();
        idle(2);
        @(negedge clk) rst_n = 1'b1;
        idle(12);
        checkOutput("rst_no_done", 32'(done_any), 32'd0);
        checkOutput("rst_cnt", stall_cnt, 32'd0);

        // Random traffic with small register indices so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            logic rq;
            rq = ($urandom_range(0, 4) == 0);
            applyStimulus(r_t'($urandom_range(0, 3)), r_t'($urandom_range(0, 3)),
                          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                          r_t'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                          rq, rq ? logic'($urandom_range(0, 1)) : logic'(1'b0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
